// File: rtl/adc_readout_pkg.sv
// rtl/adc_readout_pkg.sv - shared state type, framing constants and header builder
package adc_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        TERM   = 2'd3
    } rd_state_e;

    localparam logic [3:0]  HEADER_MAGIC = 4'hA;
    localparam logic [63:0] TERM_WORD    = '1;

    // Magic nibble in the top four bits of a data_width word, event number in the low bits.
    function automatic logic [63:0] build_header(input logic [31:0] id, input int data_width);
        return (64'(HEADER_MAGIC) << (data_width - 4)) | 64'(id);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry output buffer holding stream words stable until accepted
module axis_skid_buffer
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    logic [DATA_WIDTH+1:0] mem [2];
    logic                  wptr, rptr;
    logic                  pop;

    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = (count != 2'd0);
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem[rptr];

    // The writer never pushes into a full buffer, so the head entry is untouched until popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (s_axis_tvalid) begin
                mem[wptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, s_axis_tvalid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/adc_fifo_reader.sv
// rtl/adc_fifo_reader.sv - frames ADC FIFO samples into header + NUM_DATA word AXI-Stream packets
// Define READOUT_TIMEOUT_EN for the stall timeout that closes a short packet with a terminator word.
module adc_fifo_reader
    import adc_readout_pkg::*;
#(
    parameter int NUM_DATA       = 1280,
    parameter int DATA_WIDTH     = 32,
    parameter int EVENT_ID_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     fifo_dout,
    input  logic                      fifo_empty,
    output logic                      fifo_rd_en,
    input  logic [EVENT_ID_WIDTH-1:0] event_id,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      busy,
    output logic [EVENT_ID_WIDTH-1:0] events_sent,
    output logic                      timeout_err
);

    localparam int               CNT_W    = $clog2(NUM_DATA + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DATA - 1);
    localparam logic [CNT_W-1:0] N_WORDS  = CNT_W'(NUM_DATA);

    rd_state_e             state, state_nxt;
    logic [CNT_W-1:0]      rd_cnt, sample_cnt;
    logic                  rd_pending, rd_pending_last;
    logic [1:0]            buf_count;
    logic [2:0]            occ_next;
    logic                  beat, event_done;
    logic                  push, push_last, push_user;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  stall_limit;

    assign beat     = m_axis_tvalid && m_axis_tready;
    assign busy     = (state != IDLE);
    // Occupancy after this edge; counting the pop lets reads stream at one word per cycle.
    assign occ_next = {1'b0, buf_count} + {2'b0, rd_pending} - {2'b0, beat};

    axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (push_data),
        .s_axis_tvalid (push),
        .s_axis_tlast  (push_last),
        .s_axis_tuser  (push_user),
        .count         (buf_count),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

`ifdef READOUT_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall;

    assign stall       = (state == DATA) && (buf_count == 2'd0) && !rd_pending && fifo_empty;
    assign stall_limit = stall && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != DATA || fifo_rd_en) begin
                stall_cnt <= '0;
            end else if (stall) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (state == TERM && beat) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign stall_limit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_data  = fifo_dout;
        push_last  = rd_pending_last;
        push_user  = 1'b0;
        fifo_rd_en = 1'b0;
        event_done = 1'b0;
        case (state)
            IDLE: begin
                // The header is captured into the buffer here, which latches event_id.
                if (!fifo_empty) begin
                    push      = 1'b1;
                    push_data = DATA_WIDTH'(build_header(32'(event_id), DATA_WIDTH));
                    push_last = 1'b0;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (beat) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                push       = rd_pending;
                fifo_rd_en = !fifo_empty && (occ_next < 3'd2) && (rd_cnt < N_WORDS);
                if (beat && sample_cnt == LAST_IDX) begin
                    event_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (stall_limit) begin
                    push      = 1'b1;
                    push_data = DATA_WIDTH'(TERM_WORD);
                    push_last = 1'b1;
                    push_user = 1'b1;
                    state_nxt = TERM;
                end
            end
`ifdef READOUT_TIMEOUT_EN
            TERM: begin
                if (beat) begin
                    event_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rd_cnt          <= '0;
            sample_cnt      <= '0;
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            events_sent     <= '0;
        end else begin
            state           <= state_nxt;
            rd_pending      <= fifo_rd_en;
            rd_pending_last <= fifo_rd_en && (rd_cnt == LAST_IDX);
            if (state == IDLE) begin
                rd_cnt     <= '0;
                sample_cnt <= '0;
            end else begin
                if (fifo_rd_en) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
                if (state == DATA && beat) begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
            if (event_done) begin
                events_sent <= events_sent + EVENT_ID_WIDTH'(1);
            end
        end
    end

endmodule
